// File: rtl/adder_operand_sequencer.sv
// Sequences two operands from one byte stream into an external adder and returns sum+carry; result valid 1 cycle after B accept.
// Backpressure: res_ready low parks the FSM in S_OUT with in_ready low until the result is taken.
module adder_operand_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] sum_in,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_SUM = 2'd2,
        S_OUT = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [WIDTH-1:0]   res_data_q;
    logic               res_carry_q;
    logic               res_valid_q;
    logic [CNT_W-1:0]   op_count_q;
    logic               in_fire;

    assign in_ready = (state_q == S_A) || (state_q == S_B);
    assign in_fire  = in_valid && in_ready;
    assign busy     = (state_q != S_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (in_fire) begin
                        op_a_q  <= in_data;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (in_fire) begin
                        op_b_q  <= in_data;
                        state_q <= S_SUM;
                    end
                end
                S_SUM: begin
                    // Adder wraps mod 2^WIDTH, so a sum below op_a means carry-out.
                    res_data_q  <= sum_in;
                    res_carry_q <= (sum_in < op_a_q);
                    res_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (res_valid_q && res_ready) begin
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 1'b1;
                        state_q     <= S_A;
                    end
                end
                default: state_q <= S_A;
            endcase
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_valid = res_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer; the external adder is modelled as op_a+op_b.
module tb_adder_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] sum_in;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] op_count;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    assign sum_in = 8'(op_a + op_b);

    adder_operand_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sum_in    (sum_in),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .op_count  (op_count),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        int   n;
        logic acc;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 20);
        in_valid = 1'b0;
        check("feed_accept", 32'(acc), 32'd1);
    endtask

    task automatic get_result(output logic [7:0] d, output logic c);
        int n;
        n         = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        check("res_valid_wait", 32'(res_valid), 32'd1);
        d = res_data;
        c = res_carry;
        step();
        res_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic add_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp_s, input logic exp_c);
        logic [7:0] s;
        logic       c;
        feed(a);
        feed(b);
        get_result(s, c);
        check({tag, "_sum"}, 32'(s), 32'(exp_s));
        check({tag, "_carry"}, 32'(c), 32'(exp_c));
        check({tag, "_count"}, 32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic       c;

        // Reset with a live operand on the input.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        res_ready = 1'b0;
        step();
        step();
        check("rst_op_a", 32'(op_a), 32'h0);
        check("rst_op_b", 32'(op_b), 32'h0);
        check("rst_res_data", 32'(res_data), 32'h0);
        check("rst_res_carry", 32'(res_carry), 32'h0);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_op_count", 32'(op_count), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Basic add with cycle-exact latency.
        res_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h12;
        step();
        check("basic_op_a", 32'(op_a), 32'h12);
        check("basic_busy_b", 32'(busy), 32'h1);
        check("basic_in_ready_b", 32'(in_ready), 32'h1);
        in_data = 8'h34;
        step();
        in_valid = 1'b0;
        check("basic_op_b", 32'(op_b), 32'h34);
        check("basic_in_ready_sum", 32'(in_ready), 32'h0);
        check("basic_res_valid_early", 32'(res_valid), 32'h0);
        step();
        check("basic_res_valid", 32'(res_valid), 32'h1);
        check("basic_res_data", 32'(res_data), 32'h46);
        check("basic_res_carry", 32'(res_carry), 32'h0);
        step();
        res_ready = 1'b0;
        exp_cnt   = 8'd1;
        check("basic_res_valid_done", 32'(res_valid), 32'h0);
        check("basic_op_count", 32'(op_count), 32'h1);
        check("basic_busy_idle", 32'(busy), 32'h0);

        // Carry / wrap cases.
        add_check("wrap_f0_20", 8'hF0, 8'h20, 8'h10, 1'b1);
        add_check("wrap_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        add_check("zero_00_00", 8'h00, 8'h00, 8'h00, 1'b0);
        add_check("nowrap_80_7f", 8'h80, 8'h7F, 8'hFF, 1'b0);

        // Backpressure: result held while upstream keeps offering 0x77.
        feed(8'h3C);
        feed(8'h55);
        step();
        check("bp_res_valid", 32'(res_valid), 32'h1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_res_data", 32'(res_data), 32'h91);
            check("bp_op_a", 32'(op_a), 32'h3C);
            check("bp_op_b", 32'(op_b), 32'h55);
            check("bp_count_hold", 32'(op_count), 32'(exp_cnt));
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        exp_cnt++;
        check("bp_count_inc", 32'(op_count), 32'(exp_cnt));
        check("bp_idle", 32'(busy), 32'h0);
        check("bp_res_valid_done", 32'(res_valid), 32'h0);
        step();
        check("bp_count_once", 32'(op_count), 32'(exp_cnt));
        check("bp_op_a_kept", 32'(op_a), 32'h3C);

        // Gapped input stream.
        in_valid = 1'b1;
        in_data  = 8'h05;
        step();
        in_valid = 1'b0;
        in_data  = 8'hAA;
        step();
        step();
        check("gap_op_a", 32'(op_a), 32'h05);
        check("gap_op_b_hold", 32'(op_b), 32'h55);
        check("gap_busy", 32'(busy), 32'h1);
        in_valid = 1'b1;
        in_data  = 8'h07;
        step();
        in_valid = 1'b0;
        check("gap_op_b", 32'(op_b), 32'h07);
        get_result(s, c);
        check("gap_sum", 32'(s), 32'h0C);
        check("gap_carry", 32'(c), 32'h0);

        // Counter wrap after exactly 256 completions from reset.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            feed(8'(i));
            feed(8'h01);
            get_result(s, c);
        end
        check("cnt_wrap", 32'(op_count), 32'h0);
        check("cnt_wrap_last_sum", 32'(s), 32'h00);
        check("cnt_wrap_last_carry", 32'(c), 32'h1);

        // Reset while waiting for B discards the partial operand.
        feed(8'h09);
        check("mid_op_a", 32'(op_a), 32'h09);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_cnt = 8'd0;
        check("mid_rst_op_a", 32'(op_a), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h1);
        add_check("mid_after", 8'h01, 8'h02, 8'h03, 1'b0);
        check("mid_count_one", 32'(op_count), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
